// File: rtl/seg7_pkg.sv
// Shared types, constants and segment decode for the 4-digit scan driver.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package seg7_pkg;

  // Conversion engine states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    COMMIT = 2'd3
  } conv_state_t;

  localparam int NUM_DIGITS  = 4;
  localparam int BIN_WIDTH   = 14;
  localparam int BCD_WIDTH   = 4 * NUM_DIGITS;
  localparam int MAX_DISPLAY = 9999;

  // Typed copies so comparisons and loads stay width-exact.
  localparam logic [BIN_WIDTH-1:0] MAX_DISPLAY_BIN = BIN_WIDTH'(MAX_DISPLAY);
  localparam logic [3:0]           SHIFT_COUNT     = 4'(BIN_WIDTH);

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // BCD nibble to active-low segment pattern; non-decimal codes go blank.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter holding the last shown digits.
// Latency: 16 clocks from the IDLE capture edge to the bcd_out/overflow update (busy high 15 cycles).
// Backpressure: none; bin_in is sampled only in IDLE, changes during a conversion are picked up afterwards.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIN_WIDTH-1:0] bin_in,
  output logic [BCD_WIDTH-1:0] bcd_out,
  output logic                 overflow,
  output logic                 busy
);

  conv_state_t          state_q, state_d;
  logic [BIN_WIDTH-1:0] last_value_q, last_value_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_WIDTH-1:0] bcd_q, bcd_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [BCD_WIDTH-1:0] shown_q, shown_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;

  // Add-3 correction of the accumulator ahead of each shift.
  logic [BCD_WIDTH-1:0] bcd_adj;

  // Per-nibble add-3 for every digit that would exceed 9 after doubling.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state and datapath for the IDLE/LOAD/SHIFT/COMMIT engine.
  always_comb begin
    state_d      = state_q;
    last_value_d = last_value_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    shown_d      = shown_q;
    ovf_d        = ovf_q;
    busy_d       = busy_q;

    case (state_q)
      IDLE: begin
        if (bin_in != last_value_q) begin
          last_value_d = bin_in;
          bin_d        = bin_in;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        bcd_d   = '0;
        cnt_d   = SHIFT_COUNT;
        busy_d  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        // Bits shifted past the thousands nibble only matter for values
        // above 9999, which are shown as dashes anyway.
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (last_value_q > MAX_DISPLAY_BIN) begin
          // Keep the previous digits; the flag alone selects dashes.
          ovf_d = 1'b1;
        end else begin
          shown_d = bcd_q;
          ovf_d   = 1'b0;
        end
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_value_q <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      shown_q      <= '0;
      ovf_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_value_q <= last_value_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      shown_q      <= shown_d;
      ovf_q        <= ovf_d;
      busy_q       <= busy_d;
    end
  end

  assign bcd_out  = shown_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed common-anode 7-segment driver; optional LEADING_ZERO_BLANK_EN blanks leading zeros.
// Latency: conversion 16 clocks after capture; scan outputs registered one clock after the digit index.
// Backpressure: none; input changes during a conversion are held off until the engine returns to IDLE.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_OVERFLOW = 2**19 - 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] to_display_nr,
  output logic [3:0]  digit_select,
  output logic [6:0]  led_select,
  output logic        busy
);

  localparam int CNT_W = (REFRESH_OVERFLOW < 1) ? 1 : $clog2(REFRESH_OVERFLOW + 1);
  localparam logic [CNT_W-1:0] REFRESH_TERM = CNT_W'(REFRESH_OVERFLOW);

  logic [BCD_WIDTH-1:0] shown_bcd;
  logic                 shown_ovf;
  logic                 conv_busy;

  logic [CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]       digit_idx_q, digit_idx_d;
  logic [3:0]       digit_select_q, digit_select_d;
  logic [6:0]       led_select_q, led_select_d;
  logic [3:0]       cur_nibble;

  bin2bcd_seq u_bin2bcd (
    .clk      (clk),
    .reset    (reset),
    .bin_in   (to_display_nr),
    .bcd_out  (shown_bcd),
    .overflow (shown_ovf),
    .busy     (conv_busy)
  );

  // Refresh divider: the digit index steps once per counter wrap.
  always_comb begin
    refresh_cnt_d = refresh_cnt_q;
    digit_idx_d   = digit_idx_q;
    if (refresh_cnt_q == REFRESH_TERM) begin
      refresh_cnt_d = '0;
      digit_idx_d   = digit_idx_q + 2'd1;
    end else begin
      refresh_cnt_d = refresh_cnt_q + CNT_W'(1);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every digit to its left are zero; ones never blanks.
  logic [NUM_DIGITS-1:0] lz_blank;
  always_comb begin
    lz_blank    = '0;
    lz_blank[3] = (shown_bcd[15:12] == 4'd0);
    lz_blank[2] = lz_blank[3] && (shown_bcd[11:8] == 4'd0);
    lz_blank[1] = lz_blank[2] && (shown_bcd[7:4] == 4'd0);
  end
`endif

  // Anode and segment pattern for the digit currently selected by the index.
  always_comb begin
    cur_nibble     = shown_bcd[{digit_idx_q, 2'b00} +: 4];
    digit_select_d = ~(4'b0001 << digit_idx_q);
    led_select_d   = seg7_decode(cur_nibble);
    if (shown_ovf) begin
      led_select_d = SEG_DASH;
    end
`ifdef LEADING_ZERO_BLANK_EN
    else if (lz_blank[digit_idx_q]) begin
      // The anode still scans so all positions share the same duty cycle.
      led_select_d = SEG_BLANK;
    end
`endif
  end

  // Scan counters and registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt_q  <= '0;
      digit_idx_q    <= 2'd0;
      digit_select_q <= 4'b1111;
      led_select_q   <= SEG_BLANK;
    end else begin
      refresh_cnt_q  <= refresh_cnt_d;
      digit_idx_q    <= digit_idx_d;
      digit_select_q <= digit_select_d;
      led_select_q   <= led_select_d;
    end
  end

  assign digit_select = digit_select_q;
  assign led_select   = led_select_q;
  assign busy         = conv_busy;

endmodule
